cpu_run_ctrl: RTL

//   Synthesisable run controller for the 5-stage pipelined CPU. Replaces fixed
//   sim-time reset/stop with cycle-accurate control: it sequences core reset,

---
 rtl/cpu_run_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 5-stage CPU: sequences core reset, counts run cycles,
// drains after halt and enforces a cycle budget. Define RUN_CTRL_PERF_EN to count retired instructions.
module cpu_run_ctrl #(
  parameter int CNT_W        = 16,
  parameter int RST_CYCLES   = 2,
  parameter int MAX_CYCLES   = 50,
  parameter int DRAIN_CYCLES = 4,
  parameter int AUTO_START   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             instr_retire,
  output logic             cpu_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               WD_LAST  = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;
  localparam logic [7:0]       RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0]       DRN_LAST = 8'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic       wd_fire;
  logic       run_begin;
  logic       active;

  always_comb begin
    state_next = state;
    timer_next = timer;
    wd_fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (AUTO_START != 0 || start) begin
          state_next = S_RESET;
          timer_next = '0;
        end
      end
      S_RESET: begin
        if (timer == RST_LAST) state_next = S_RUN;
        else                   timer_next = timer + 8'd1;
      end
      S_RUN: begin
        // Halt has priority over the watchdog so a run that halts on its
        // last budgeted cycle is still reported as a clean finish.
        if (halt_req) begin
          state_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          timer_next = '0;
        end else if (MAX_CYCLES != 0 && 32'(cycle_cnt) == 32'(WD_LAST)) begin
          state_next = S_DONE;
          wd_fire    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (timer == DRN_LAST) state_next = S_DONE;
        else                   timer_next = timer + 8'd1;
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RESET;
          timer_next = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign run_begin = (state_next == S_RESET) && (state != S_RESET);
  assign active    = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (run_begin) begin
        cycle_cnt <= '0;
        timeout   <= 1'b0;
      end else begin
        if (active && cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
        if (wd_fire) timeout <= 1'b1;
      end
    end
  end

`ifdef RUN_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (run_begin) begin
      retire_cnt <= '0;
    end else if (active && instr_retire && retire_cnt != CNT_MAX) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign retire_cnt    = '0;
`endif

  assign cpu_rst = (state == S_IDLE) || (state == S_RESET);
  assign running = active;
  assign done    = (state == S_DONE);

endmodule
